// File: rtl/mem_arbiter.sv
// Shared memory-port arbiter for the I-cache and D-cache miss handlers.
// Fixed priority (D write > D fill > I fill). Line fills are sent to a pipelined fixed-latency memory.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; arbitrate requests and latch address/write data
// I_FILL  | I-cache owns memory; issue line reads and collect returns
// D_FILL  | D-cache owns memory; issue line reads and collect returns
// D_WRITE | single-cycle D-cache word write, d_done pulses here

module mem_arbiter #(
   parameter int WORDS_PER_LINE = 8,
   parameter int MEM_LATENCY    = 4,
   localparam int IDX_W         = $clog2(WORDS_PER_LINE)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_req,
   input  logic [15:0]      i_addr,
   output logic             i_grant,
   output logic             i_data_valid,
   output logic [IDX_W-1:0] i_word,
   output logic             i_done,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [15:0]      d_addr,
   input  logic [15:0]      d_wdata,
   output logic             d_grant,
   output logic             d_data_valid,
   output logic [IDX_W-1:0] d_word,
   output logic             d_done,
   output logic [15:0]      rdata,
   output logic             mem_en,
   output logic             mem_wr,
   output logic [15:0]      mem_addr,
   output logic [15:0]      mem_wdata,
   input  logic [15:0]      mem_rdata,
   input  logic             mem_rvalid
);

   localparam int             FL_W      = $clog2(MEM_LATENCY + 1);
   localparam logic [15:0]    LINE_MASK = ~16'(2 * WORDS_PER_LINE - 1);
   localparam logic [IDX_W:0] ISS_MAX   = (IDX_W + 1)'(WORDS_PER_LINE);
   localparam logic [IDX_W-1:0] RCV_LAST = IDX_W'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

   state_t           state, state_nxt;
   logic [IDX_W:0]   iss;
   logic [IDX_W-1:0] rcv;
   logic [15:0]      addr_q, wdata_q, offs;
   logic [FL_W-1:0]  flush;
   logic             fill, rvalid_ok, last_word, issue;

   // Reads issued before a reset can still return for MEM_LATENCY cycles
   // afterwards; the flush timer masks them so a new fill is not polluted.
   assign fill      = (state == I_FILL) || (state == D_FILL);
   assign rvalid_ok = mem_rvalid && (flush == '0);
   assign last_word = fill && rvalid_ok && (rcv == RCV_LAST);
   assign issue     = fill && (iss < ISS_MAX);
   assign offs      = 16'({iss[IDX_W-1:0], 1'b0});

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         iss     <= '0;
         rcv     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         flush   <= FL_W'(MEM_LATENCY);
      end else begin
         state <= state_nxt;
         if (flush != '0)
            flush <= flush - FL_W'(1);
         if (state == IDLE) begin
            iss     <= '0;
            rcv     <= '0;
            wdata_q <= d_wdata;
            if (d_req && d_we)
               addr_q <= d_addr & 16'hFFFE;
            else if (d_req)
               addr_q <= d_addr & LINE_MASK;
            else
               addr_q <= i_addr & LINE_MASK;
         end else begin
            if (issue)
               iss <= iss + (IDX_W + 1)'(1);
            if (fill && rvalid_ok)
               rcv <= rcv + IDX_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (d_req)
               state_nxt = d_we ? D_WRITE : D_FILL;
            else if (i_req)
               state_nxt = I_FILL;
         end
         I_FILL, D_FILL: begin
            if (last_word)
               state_nxt = IDLE;
         end
         D_WRITE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign i_grant      = (state == I_FILL);
   assign d_grant      = (state == D_FILL) || (state == D_WRITE);
   assign mem_en       = issue || (state == D_WRITE);
   assign mem_wr       = (state == D_WRITE);
   assign mem_addr     = issue ? (addr_q | offs) : ((state == D_WRITE) ? addr_q : 16'h0000);
   assign mem_wdata    = (state == D_WRITE) ? wdata_q : 16'h0000;
   assign i_data_valid = (state == I_FILL) && rvalid_ok;
   assign d_data_valid = (state == D_FILL) && rvalid_ok;
   assign i_word       = (state == I_FILL) ? rcv : '0;
   assign d_word       = (state == D_FILL) ? rcv : '0;
   assign i_done       = (state == I_FILL) && last_word;
   assign d_done       = ((state == D_FILL) && last_word) || (state == D_WRITE);
   assign rdata        = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a vector table for single-cycle writes and
// arbitration, plus hand-written fill, reset and spurious-return sequences against a latency-L memory model.

module tb_mem_arbiter;

   localparam int W  = 8;
   localparam int L  = 4;
   localparam int IW = $clog2(W);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [15:0]   i_addr = '0, d_addr = '0, d_wdata = '0;
   logic          i_grant, i_data_valid, i_done, d_grant, d_data_valid, d_done;
   logic [IW-1:0] i_word, d_word;
   logic [15:0]   rdata, mem_addr, mem_wdata, mem_rdata;
   logic          mem_en, mem_wr, mem_rvalid;

   int n_tests = 0;
   int n_fail  = 0;

   mem_arbiter #(.WORDS_PER_LINE(W), .MEM_LATENCY(L)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data_valid(i_data_valid),
      .i_word(i_word), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_grant(d_grant),
      .d_data_valid(d_data_valid), .d_word(d_word), .d_done(d_done),
      .rdata(rdata), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
   );

   always #5 clk = ~clk;

   // Memory model: read issued in cycle c returns ~address in cycle c+L.
   logic [L-1:0] pv = '0;
   logic [15:0]  pa [L];
   logic         cap_v = 1'b0;
   logic [15:0]  cap_a = '0;
   logic         spur = 1'b0;

   always @(negedge clk) begin
      cap_v <= mem_en && !mem_wr;
      cap_a <= mem_addr;
   end

   always @(posedge clk) begin
      pv    <= {pv[L-2:0], cap_v};
      pa[0] <= cap_a;
      for (int k = 1; k < L; k++) pa[k] <= pa[k-1];
   end

   assign mem_rvalid = pv[L-1] | spur;
   assign mem_rdata  = pv[L-1] ? ~pa[L-1] : 16'h1234;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, " i_grant"}, 32'(i_grant), 0);
      chk({tag, " d_grant"}, 32'(d_grant), 0);
      chk({tag, " mem_en"}, 32'(mem_en), 0);
      chk({tag, " mem_wr"}, 32'(mem_wr), 0);
      chk({tag, " i_data_valid"}, 32'(i_data_valid), 0);
      chk({tag, " d_data_valid"}, 32'(d_data_valid), 0);
      chk({tag, " i_done"}, 32'(i_done), 0);
      chk({tag, " d_done"}, 32'(d_done), 0);
   endtask

   // Entered in the grant cycle (c=1); checks through the first IDLE cycle (c=W+L+1).
   task automatic fill_check(input bit own_d, input logic [15:0] base, input int drop_at);
      bit            is_iss, is_val, owns;
      logic [15:0]   ea, ed;
      logic [IW-1:0] ew;
      for (int c = 1; c <= W + L + 1; c++) begin
         is_iss = (c <= W);
         is_val = (c > L) && (c <= W + L);
         owns   = (c <= W + L);
         ea     = is_iss ? base + 16'(2 * (c - 1)) : 16'h0000;
         ed     = ~(base + 16'(2 * (c - L - 1)));
         ew     = IW'(c - L - 1);
         chk("fill i_grant", 32'(i_grant), 32'(owns && !own_d));
         chk("fill d_grant", 32'(d_grant), 32'(owns && own_d));
         chk("fill mem_en", 32'(mem_en), 32'(is_iss));
         chk("fill mem_wr", 32'(mem_wr), 0);
         chk("fill mem_addr", 32'(mem_addr), 32'(ea));
         chk("fill i_data_valid", 32'(i_data_valid), 32'(is_val && !own_d));
         chk("fill d_data_valid", 32'(d_data_valid), 32'(is_val && own_d));
         chk("fill i_done", 32'(i_done), 32'((c == W + L) && !own_d));
         chk("fill d_done", 32'(d_done), 32'((c == W + L) && own_d));
         if (is_val) begin
            chk("fill word", own_d ? 32'(d_word) : 32'(i_word), 32'(ew));
            chk("fill rdata", 32'(rdata), 32'(ed));
         end
         if (c == drop_at || c == W + L) begin
            if (own_d) d_req = 1'b0;
            else       i_req = 1'b0;
         end
         if (c < W + L + 1) step();
      end
   endtask

   typedef struct {
      logic        i_req;
      logic [15:0] i_addr;
      logic        d_req;
      logic        d_we;
      logic [15:0] d_addr;
      logic [15:0] d_wdata;
      logic        e_ig, e_dg, e_en, e_wr;
      logic [15:0] e_addr, e_wdata;
      logic        e_idone, e_ddone;
   } vec_t;

   localparam int NV = 7;
   vec_t vecs [NV];

   initial begin
      vecs[0] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h00A5, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A4, 16'hBEEF, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h00A5, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h00A5, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A4, 16'hBEEF, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 16'h2000, 1'b1, 1'b1, 16'h1235, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 16'h2000, 1'b1, 1'b1, 16'h1235, 16'h0042, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h0042, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};

      // Reset state
      for (int k = 0; k < 3; k++) begin
         step();
         check_idle("reset");
         chk("reset mem_addr", 32'(mem_addr), 0);
         chk("reset rdata", 32'(rdata), 32'h1234);
      end
      rst_n = 1'b1;
      repeat (L + 1) step();

      // Writes and arbitration priority
      for (int k = 0; k < NV; k++) begin
         i_req = vecs[k].i_req;   i_addr  = vecs[k].i_addr;
         d_req = vecs[k].d_req;   d_we    = vecs[k].d_we;
         d_addr = vecs[k].d_addr; d_wdata = vecs[k].d_wdata;
         step();
         chk("vec i_grant", 32'(i_grant), 32'(vecs[k].e_ig));
         chk("vec d_grant", 32'(d_grant), 32'(vecs[k].e_dg));
         chk("vec mem_en", 32'(mem_en), 32'(vecs[k].e_en));
         chk("vec mem_wr", 32'(mem_wr), 32'(vecs[k].e_wr));
         chk("vec mem_addr", 32'(mem_addr), 32'(vecs[k].e_addr));
         chk("vec mem_wdata", 32'(mem_wdata), 32'(vecs[k].e_wdata));
         chk("vec i_done", 32'(i_done), 32'(vecs[k].e_idone));
         chk("vec d_done", 32'(d_done), 32'(vecs[k].e_ddone));
         chk("vec i_data_valid", 32'(i_data_valid), 0);
         chk("vec d_data_valid", 32'(d_data_valid), 0);
      end

      // I-cache line fill
      i_req = 1'b1; i_addr = 16'h1236;
      step();
      fill_check(1'b0, 16'h1230, 0);

      // Simultaneous requests: D fill first, I fill two cycles after d_done
      i_req = 1'b1; i_addr = 16'h3000;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h4000;
      step();
      fill_check(1'b1, 16'h4000, 0);
      step();
      fill_check(1'b0, 16'h3000, 0);

      // Requester drops i_req right after grant
      i_req = 1'b1; i_addr = 16'h0F0E;
      step();
      fill_check(1'b0, 16'h0F00, 1);

      // Reset after the third word returns, then immediate re-request
      i_req = 1'b1; i_addr = 16'h0806;
      step();
      repeat (L + 2) step();
      chk("rst3 i_data_valid", 32'(i_data_valid), 1);
      chk("rst3 i_word", 32'(i_word), 2);
      rst_n = 1'b0; i_req = 1'b0;
      step();
      check_idle("midreset");
      chk("midreset rdata", 32'(rdata), 32'(mem_rdata));
      rst_n = 1'b1; i_req = 1'b1;
      step();
      fill_check(1'b0, 16'h0800, 0);

      // Spurious mem_rvalid while IDLE
      spur = 1'b1;
      #1;
      chk("spur i_data_valid", 32'(i_data_valid), 0);
      chk("spur d_data_valid", 32'(d_data_valid), 0);
      step();
      check_idle("spur");
      spur = 1'b0;
      step();
      check_idle("after spur");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
